cache_controller: RTL

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// Two-way set-associative cache controller: tag/valid/dirty/LRU state, write-back, write-allocate.
// Optional hit/miss statistics counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_controller #(
    parameter int ADDR_WIDTH  = 32,
    parameter int N_WAYS      = 2,
    parameter int NUM_SETS    = 16,
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 4,
    parameter int TAG_BITS    = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    output logic                  cpu_req_ready,
    output logic                  cpu_resp_valid,
    output logic                  cpu_resp_hit,
    output logic                  data_way,
    output logic [INDEX_BITS-1:0] data_index,
    output logic                  data_we,
    output logic                  mem_req_valid,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic                  req_we;
    logic                  hit_q;
    logic                  way_q;
    logic                  resp_valid_q;
    logic                  resp_hit_q;

    logic [N_WAYS-1:0]   valid [NUM_SETS];
    logic [N_WAYS-1:0]   dirty [NUM_SETS];
    logic [NUM_SETS-1:0] lru;
    logic [TAG_BITS-1:0] tags  [NUM_SETS][N_WAYS];

    logic [N_WAYS-1:0] way_hit;
    logic              hit;
    logic              hit_way;
    logic              victim;
    logic              victim_dirty;
    logic              unused_offset;

    assign unused_offset = ^cpu_req_addr[OFFSET_BITS-1:0];

    always_comb begin
        for (int w = 0; w < N_WAYS; w++) begin
            way_hit[w] = valid[req_idx][w] && (tags[req_idx][w] == req_tag);
        end
    end

    assign hit     = |way_hit;
    assign hit_way = ~way_hit[0];

    // Fill an empty way before evicting anything; way 0 wins a tie.
    always_comb begin
        if (!valid[req_idx][0]) begin
            victim = 1'b0;
        end else if (!valid[req_idx][1]) begin
            victim = 1'b1;
        end else begin
            victim = lru[req_idx];
        end
    end

    assign victim_dirty = valid[req_idx][victim] && dirty[req_idx][victim];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cpu_req_valid) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_nxt = RESP;
                end else if (victim_dirty) begin
                    state_nxt = WRITEBACK;
                end else begin
                    state_nxt = FILL;
                end
            end
            WRITEBACK: begin
                if (mem_ack) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    state_nxt = RESP;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        data_we       = 1'b0;
        data_way      = 1'b0;
        data_index    = '0;
        unique case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
            end
            LOOKUP: begin
                data_index = req_idx;
                data_way   = hit ? hit_way : victim;
                data_we    = hit && req_we;
            end
            WRITEBACK: begin
                data_index    = req_idx;
                data_way      = way_q;
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tags[req_idx][way_q], req_idx,
                                 {OFFSET_BITS{1'b0}}};
            end
            FILL: begin
                data_index    = req_idx;
                data_way      = way_q;
                data_we       = mem_ack;
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
            end
            RESP: begin
                data_index = req_idx;
                data_way   = way_q;
            end
            default: ;
        endcase
    end

    // The completion pulse is registered out of RESP, giving a 3-cycle hit.
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_hit   = resp_hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_tag      <= '0;
            req_idx      <= '0;
            req_we       <= 1'b0;
            hit_q        <= 1'b0;
            way_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            lru          <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
            end
        end else begin
            resp_valid_q <= (state == RESP);
            resp_hit_q   <= (state == RESP) && hit_q;
            unique case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_tag <= cpu_req_addr[ADDR_WIDTH-1 -: TAG_BITS];
                        req_idx <= cpu_req_addr[OFFSET_BITS +: INDEX_BITS];
                        req_we  <= cpu_req_we;
                    end
                end
                LOOKUP: begin
                    hit_q <= hit;
                    way_q <= hit ? hit_way : victim;
                    if (hit) begin
                        lru[req_idx] <= ~hit_way;
                        if (req_we) begin
                            dirty[req_idx][hit_way] <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid[req_idx][way_q] <= 1'b1;
                        dirty[req_idx][way_q] <= req_we;
                        lru[req_idx]          <= ~way_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == FILL && mem_ack) begin
            tags[req_idx][way_q] <= req_tag;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state == RESP) begin
            if (hit_q && !(&hits_q)) begin
                hits_q <= hits_q + 32'd1;
            end
            if (!hit_q && !(&misses_q)) begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign hit_count  = hits_q;
    assign miss_count = misses_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
